timer_dev: RTL and testbench

//  Programmable down-counter peripheral on the processor bus, downstream of the bridge that decodes PrAddr/PrWe from mips.

---
 rtl/timer_dev_pkg.sv | 33 +++
 rtl/timer_dev.sv | 131 +++++++++++++
 tb/tb_timer_dev.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_dev_pkg.sv
// timer_dev_pkg
//   Shared definitions for the timer_dev bus peripheral: word offsets of the
//   register file, CTRL field positions, mode codes and the FSM state type.
//   There are no ports; the package is imported by timer_dev.
package timer_dev_pkg;

    // Word offsets (PrAddr[3:2]) decoded inside the timer.
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    // CTRL layout: [3] IM, [2:1] Mode, [0] Enable.
    localparam int unsigned CTRL_W       = 4;
    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_MODE_LO = 1;
    localparam int unsigned CTRL_MODE_HI = 2;
    localparam int unsigned CTRL_IM      = 3;

    // Only 2'b01 reloads; every other Mode code behaves as one-shot.
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    function automatic logic mode_is_reload(input logic [1:0] mode);
        return mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_dev.sv
// timer_dev
//   Programmable down-counter on the processor bus. CTRL, PRESET and COUNT
//   are word registers; COUNT reaching zero sets an interrupt flag that is
//   presented on IRQ when CTRL.IM is set. One-shot and auto-reload modes,
//   pause/resume via CTRL.Enable.
// Ports
//   clk   in   1   system clock, all state on rising edge
//   rst   in   1   asynchronous active-low reset
//   Addr  in   2   word offset: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved
//   WE    in   1   write strobe (already chip-select qualified)
//   DIn   in   32  write data
//   DOut  out  32  read data, combinational on Addr
//   IRQ   out  1   level interrupt = irq_flag & CTRL.IM
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] DIn,
    output logic [31:0] DOut,
    output logic        IRQ
);

    state_e              state_q, state_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [WIDTH-1:0]    preset_q, preset_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic                irq_flag_q, irq_flag_d;

    logic                enable;
    logic [1:0]          mode;
    logic                wr_ctrl;
    logic                wr_preset;

    assign enable    = ctrl_q[CTRL_EN];
    assign mode      = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];
    assign wr_ctrl   = WE && (Addr == ADDR_CTRL);
    assign wr_preset = WE && (Addr == ADDR_PRESET);

    // Any write cycle freezes the counter FSM; only a PRESET write moves it
    // (back to IDLE). Writes to COUNT/reserved have no register effect.
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        if (WE) begin
            if (wr_ctrl) begin
                ctrl_d     = DIn[CTRL_W-1:0];
                irq_flag_d = 1'b0;
            end
            if (wr_preset) begin
                preset_d   = DIn[WIDTH-1:0];
                irq_flag_d = 1'b0;
                state_d    = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count_d = preset_q;
                    state_d = ST_CNT;
                end
                ST_CNT: begin
                    if (enable) begin
                        // COUNT of 0 or 1 both terminate, so PRESET=0 acts as 1
                        // and the counter can never wrap.
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end else begin
                            count_d    = '0;
                            irq_flag_d = 1'b1;
                            state_d    = ST_INT;
                        end
                    end
                end
                ST_INT: begin
                    if (mode_is_reload(mode)) begin
                        irq_flag_d = 1'b0;
                        state_d    = ST_LOAD;
                    end else begin
                        ctrl_d[CTRL_EN] = 1'b0;
                        state_d         = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        DOut = '0;
        case (Addr)
            ADDR_CTRL:   DOut[CTRL_W-1:0] = ctrl_q;
            ADDR_PRESET: DOut[WIDTH-1:0]  = preset_q;
            ADDR_COUNT:  DOut[WIDTH-1:0]  = count_q;
            default:     DOut             = '0;
        endcase
    end

    assign IRQ = irq_flag_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev
//   Scoreboard bench for timer_dev. The driver pushes the expected DOut/IRQ
//   for every cycle it drives; a negedge monitor pops and compares. Expected
//   values come from a timeline model: after a start, the observable state is
//   a closed-form function of the number of FSM-advancing edges.
module tb_timer_dev;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  Addr = '0;
    logic        WE = 1'b0;
    logic [31:0] DIn = '0;
    logic [31:0] DOut;
    logic        IRQ;

    timer_dev #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .Addr(Addr),
        .WE  (WE),
        .DIn (DIn),
        .DOut(DOut),
        .IRQ (IRQ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] dout;
        logic        irq;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // ---------------- reference model ----------------
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count_hold;   // COUNT while no timeline is running / before LOAD
    bit          m_active;       // a start has happened and not been ended
    int unsigned m_t;            // FSM-advancing edges since the start

    function automatic bit m_reload();
        return m_ctrl[2:1] == 2'b01;
    endfunction

    function automatic int unsigned m_ne();
        return (m_preset == 0) ? 1 : m_preset;
    endfunction

    // Position inside the current period: 0..ne-1 counting, ne zero+flag, ne+1 reload.
    function automatic int unsigned m_phase();
        int unsigned u;
        u = m_t - 2;
        return m_reload() ? (u % (m_ne() + 2)) : u;
    endfunction

    function automatic logic [31:0] exp_count();
        if (!m_active || m_t < 2) return m_count_hold;
        if (m_phase() < m_ne()) return m_preset - m_phase();
        return 32'd0;
    endfunction

    function automatic bit exp_flag();
        if (!m_active || m_t < 2) return 1'b0;
        if (m_reload()) return m_phase() == m_ne();
        return m_phase() >= m_ne();
    endfunction

    function automatic bit in_cnt();
        return m_active && m_t >= 2 && m_phase() < m_ne();
    endfunction

    function automatic logic [31:0] m_dout(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return exp_count();
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_irq();
        return exp_flag() & m_ctrl[3];
    endfunction

    task automatic model_reset();
        m_ctrl = '0; m_preset = '0; m_count_hold = '0; m_active = 0; m_t = 0;
    endtask

    task automatic model_edge(input logic we_v, input logic [1:0] a,
                              input logic [31:0] d, input bit end_w);
        logic [31:0] cur;
        cur = exp_count();
        if (we_v) begin
            if (a == 2'd0) begin
                if (end_w) begin
                    m_active = 0; m_count_hold = cur;
                end else if (!m_active && d[0]) begin
                    m_active = 1; m_t = 0; m_count_hold = cur;
                end
                m_ctrl = d[3:0];
            end else if (a == 2'd1) begin
                m_preset = d; m_count_hold = cur; m_active = m_ctrl[0]; m_t = 0;
            end
        end else if (m_active && m_ctrl[0]) begin
            if (!m_reload() && m_t >= 2 && m_phase() == m_ne()) m_ctrl[0] = 1'b0;
            m_t++;
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic we_v, input logic [1:0] a, input logic [31:0] d,
                        input logic [31:0] ed, input logic ei, input bit end_w);
        WE = we_v; Addr = a; DIn = d;
        sb_q.push_back('{addr: a, dout: ed, irq: ei});
        @(posedge clk); #1;
        model_edge(we_v, a, d, end_w);
    endtask

    task automatic idle(input logic [1:0] a);
        step(1'b0, a, '0, m_dout(a), m_irq(), 0);
    endtask

    task automatic obs(input logic [1:0] a, input logic [31:0] ed, input logic ei);
        step(1'b0, a, '0, ed, ei, 0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input bit end_w);
        step(1'b1, a, d, m_dout(a), m_irq(), end_w);
    endtask

    task automatic rand_read();
        int unsigned r;
        r = $urandom_range(0, 7);
        case (r)
            4:       idle(2'd0);
            5:       idle(2'd1);
            6:       idle(2'd3);
            default: idle(2'd2);
        endcase
    endtask

    task automatic run_to_done();
        for (int g = 0; g < 300 && m_ctrl[0]; g++) idle(2'd2);
        idle(2'd0);
        idle(2'd2);
    endtask

    task automatic reset_check();
        rst = 1'b0; WE = 1'b0;
        model_reset();
        for (int a = 0; a < 3; a++) begin
            Addr = 2'(a);
            sb_q.push_back('{addr: 2'(a), dout: 32'd0, irq: 1'b0});
            @(posedge clk); #1;
        end
        rst = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_tests++;
            if (DOut !== e.dout) begin
                n_fail++;
                $display("FAIL dout addr=%0d got=%h exp=%h t=%0t", e.addr, DOut, e.dout, $time);
            end
            n_tests++;
            if (IRQ !== e.irq) begin
                n_fail++;
                $display("FAIL irq addr=%0d got=%b exp=%b t=%0t", e.addr, IRQ, e.irq, $time);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        @(posedge clk); #1;
        reset_check();

        // One-shot, PRESET=3, IM=1.
        wr(2'd1, 32'd3, 0);
        wr(2'd0, 32'h9, 0);
        obs(2'd2, 32'd0, 1'b0);
        obs(2'd2, 32'd0, 1'b0);
        obs(2'd2, 32'd3, 1'b0);
        obs(2'd2, 32'd2, 1'b0);
        obs(2'd2, 32'd1, 1'b0);
        obs(2'd2, 32'd0, 1'b1);
        obs(2'd0, 32'h8, 1'b1);
        obs(2'd0, 32'h8, 1'b1);
        wr(2'd0, 32'h8, 1);
        obs(2'd0, 32'h8, 1'b0);

        // Auto-reload, PRESET=2: IRQ pulse every 4 cycles.
        wr(2'd1, 32'd2, 0);
        wr(2'd0, 32'hB, 0);
        obs(2'd2, 32'd0, 1'b0);
        obs(2'd2, 32'd0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            case (k % 4)
                0:       obs(2'd2, 32'd2, 1'b0);
                1:       obs(2'd2, 32'd1, 1'b0);
                2:       obs(2'd2, 32'd0, 1'b1);
                default: obs(2'd2, 32'd0, 1'b0);
            endcase
        end

        // Pause at COUNT=6, hold five cycles, resume without reload.
        wr(2'd1, 32'd10, 0);
        wr(2'd0, 32'h9, 0);
        for (int g = 0; g < 40 && exp_count() != 32'd6; g++) idle(2'd2);
        wr(2'd0, 32'h8, 0);
        obs(2'd2, 32'd6, 1'b0);
        obs(2'd2, 32'd6, 1'b0);
        obs(2'd2, 32'd6, 1'b0);
        wr(2'd2, 32'h1234_5678, 0);
        obs(2'd2, 32'd6, 1'b0);
        wr(2'd0, 32'h9, 0);
        obs(2'd2, 32'd6, 1'b0);
        obs(2'd2, 32'd5, 1'b0);
        obs(2'd2, 32'd4, 1'b0);
        run_to_done();
        wr(2'd0, 32'h0, 1);

        // PRESET=0 with IM=0: terminates like N=1, IRQ masked.
        wr(2'd1, 32'd0, 0);
        wr(2'd0, 32'h1, 0);
        obs(2'd2, 32'd0, 1'b0);
        obs(2'd2, 32'd0, 1'b0);
        obs(2'd2, 32'd0, 1'b0);
        obs(2'd0, 32'h1, 1'b0);
        obs(2'd0, 32'h0, 1'b0);
        wr(2'd0, 32'h0, 1);

        // PRESET write mid-count: IDLE, COUNT frozen, reload two cycles later.
        wr(2'd1, 32'd20, 0);
        wr(2'd0, 32'h9, 0);
        for (int g = 0; g < 40 && exp_count() != 32'd15; g++) idle(2'd2);
        wr(2'd1, 32'd7, 0);
        obs(2'd2, 32'd15, 1'b0);
        obs(2'd2, 32'd15, 1'b0);
        obs(2'd2, 32'd7, 1'b0);
        run_to_done();
        wr(2'd0, 32'h0, 1);

        // Register width: upper CTRL bits dropped, PRESET keeps all 32 bits.
        wr(2'd0, 32'hFFFF_FFF8, 1);
        obs(2'd0, 32'h8, 1'b0);
        wr(2'd1, 32'hDEAD_BEEF, 0);
        obs(2'd1, 32'hDEAD_BEEF, 1'b0);
        obs(2'd3, 32'h0, 1'b0);

        // Randomized scenarios.
        for (int s = 0; s < 30; s++) begin
            logic [31:0] n;
            logic [1:0]  md;
            logic        im;
            int unsigned len;
            bit          paused;
            n  = 32'($urandom_range(0, 9));
            md = 2'($urandom_range(0, 3));
            im = 1'($urandom_range(0, 1));
            paused = 0;
            wr(2'd1, n, 0);
            wr(2'd0, {28'd0, im, md, 1'b1}, 0);
            len = $urandom_range(m_ne() + 3, 3 * m_ne() + 8);
            for (int c = 0; c < int'(len); c++) begin
                if (!paused && in_cnt() && $urandom_range(0, 5) == 0) begin
                    paused = 1;
                    wr(2'd0, {28'd0, im, md, 1'b0}, 0);
                    for (int h = 0; h < int'($urandom_range(1, 4)); h++) begin
                        if ($urandom_range(0, 2) == 0)
                            wr(2'($urandom_range(2, 3)), $urandom, 0);
                        else
                            rand_read();
                    end
                    wr(2'd0, {28'd0, im, md, 1'b1}, 0);
                end else begin
                    rand_read();
                end
            end
            if (m_reload()) begin
                wr(2'd1, 32'($urandom_range(0, 9)), 0);
                idle(2'd2);
            end else begin
                run_to_done();
                wr(2'd0, {28'd0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0}, 1);
                idle(2'd0);
            end
        end

        // Reset mid-count while IRQ is high.
        wr(2'd1, 32'd1, 0);
        wr(2'd0, 32'hB, 0);
        for (int g = 0; g < 20 && !m_irq(); g++) idle(2'd2);
        reset_check();
        idle(2'd2);

        WE = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
